// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port between core and host.
// Optional timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wrbits,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        host_req,
  input  logic        host_write,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_wrbits,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wrbits,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_BUSY  = 2'd1,
    HOST_BUSY = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_host_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wrbits_q;
  logic        write_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] host_rdata_q;
  logic        cpu_ack_q;
  logic        host_ack_q;

  logic idle;
  logic busy;
  logic cpu_ok;
  logic host_ok;
  logic cpu_win;
  logic host_win;

  assign idle    = (state_q == IDLE);
  assign busy    = ~idle;
  // a port is not re-granted in its own ack cycle
  assign cpu_ok  = cpu_req & ~cpu_ack_q;
  assign host_ok = host_req & ~host_ack_q;
  assign cpu_win  = idle & cpu_ok & (~host_ok | last_host_q);
  assign host_win = idle & host_ok & ~cpu_win;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        cpu_err_q;
  logic        host_err_q;
  logic        expire;

  assign expire   = (cnt_q == 16'(TIMEOUT - 1));
  assign cpu_err  = cpu_err_q;
  assign host_err = host_err_q;
`else
  assign cpu_err  = 1'b0;
  assign host_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_host_q  <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wrbits_q     <= '0;
      write_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      cpu_err_q    <= 1'b0;
      host_err_q   <= 1'b0;
`endif
    end else begin
      cpu_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cpu_err_q  <= 1'b0;
      host_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (cpu_win | host_win) begin
            state_q     <= cpu_win ? CPU_BUSY : HOST_BUSY;
            last_host_q <= host_win;
            write_q     <= cpu_win ? cpu_write  : host_write;
            addr_q      <= cpu_win ? cpu_addr   : host_addr;
            wdata_q     <= cpu_win ? cpu_wdata  : host_wdata;
            wrbits_q    <= cpu_win ? cpu_wrbits : host_wrbits;
          end
        end
        CPU_BUSY, HOST_BUSY: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            cpu_ack_q  <= (state_q == CPU_BUSY);
            host_ack_q <= (state_q == HOST_BUSY);
            if (!write_q && state_q == CPU_BUSY)
              cpu_rdata_q <= mem_rdata;
            if (!write_q && state_q == HOST_BUSY)
              host_rdata_q <= mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (expire) begin
            state_q    <= IDLE;
            cpu_ack_q  <= (state_q == CPU_BUSY);
            host_ack_q <= (state_q == HOST_BUSY);
            cpu_err_q  <= (state_q == CPU_BUSY);
            host_err_q <= (state_q == HOST_BUSY);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;

  // memory side is quiet whenever no transfer is in flight
  assign mem_read   = busy & ~write_q;
  assign mem_write  = busy & write_q;
  assign mem_wrbits = (busy & write_q) ? wrbits_q : 4'b0000;
  assign mem_addr   = busy ? addr_q  : 32'h0;
  assign mem_wdata  = busy ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, transaction-level model checked
// against mem_arbiter every cycle, plus literal spot checks.
module tb_mem_arbiter;

  localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wrbits;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        host_req, host_write;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_wrbits;
  logic [31:0] host_rdata;
  logic        host_ack, host_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wrbits;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  logic        mem_ready = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wrbits(cpu_wrbits), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .host_req(host_req), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_wrbits(host_wrbits), .host_rdata(host_rdata),
    .host_ack(host_ack), .host_err(host_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wrbits(mem_wrbits), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // memory responder: ready on the lat-th busy cycle (lat=0: never)
  int          lat = 1;
  bit          force_rdy = 1'b0;
  logic [31:0] rd_key = 32'h0;
  int          bcnt = 0;

  always @(posedge clock) begin
    #2;
    if (mem_read | mem_write) bcnt++;
    else bcnt = 0;
    mem_ready = force_rdy |
      ((mem_read | mem_write) && lat != 0 && bcnt == lat);
    mem_rdata = mem_ready ? (mem_addr ^ rd_key) : 32'hDEADBEEF;
  end

  // transaction-level model: owner 0 = none, 1 = cpu, 2 = host
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } tx_t;

  int          m_own;
  int          m_last;
  int          m_wait;
  tx_t         m_tx;
  bit          m_ack [1:2];
  bit          m_err;
  logic [31:0] m_rd [1:2];

  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [3:0]  wr_seen = 4'h0;

  task automatic m_reset();
    m_own  = 0;
    m_last = 2;
    m_wait = 0;
    m_tx   = '{1'b0, 32'h0, 32'h0, 4'h0};
    m_ack  = '{1'b0, 1'b0};
    m_err  = 1'b0;
    m_rd   = '{32'h0, 32'h0};
  endtask

  task automatic m_step();
    bit na [1:2];
    bit ne;
    bit wc;
    bit wh;
    int w;
    na = '{1'b0, 1'b0};
    ne = 1'b0;
    w  = 0;
    if (m_own == 0) begin
      wc = cpu_req && !m_ack[1];
      wh = host_req && !m_ack[2];
      if (wc && wh) w = (m_last == 1) ? 2 : 1;
      else if (wc) w = 1;
      else if (wh) w = 2;
      if (w == 1) m_tx = '{cpu_write, cpu_addr, cpu_wdata, cpu_wrbits};
      if (w == 2) m_tx = '{host_write, host_addr, host_wdata, host_wrbits};
      if (w != 0) begin
        m_own  = w;
        m_last = w;
        m_wait = 0;
      end
    end else if (mem_ready) begin
      if (!m_tx.write) m_rd[m_own] = mem_rdata;
      na[m_own] = 1'b1;
      m_own = 0;
    end else begin
      m_wait++;
      if (TO_EN && m_wait >= TMO) begin
        na[m_own] = 1'b1;
        ne = 1'b1;
        m_own = 0;
      end
    end
    m_ack = na;
    m_err = ne;
  endtask

  always @(negedge clock) begin
    if (!reset) m_reset();
    chk("mem_read", 32'(mem_read), 32'(m_own != 0 && !m_tx.write));
    chk("mem_write", 32'(mem_write), 32'(m_own != 0 && m_tx.write));
    chk("mem_wrbits", 32'(mem_wrbits),
        (m_own != 0 && m_tx.write) ? 32'(m_tx.mask) : 32'h0);
    chk("mem_addr", mem_addr, (m_own != 0) ? m_tx.addr : 32'h0);
    chk("mem_wdata", mem_wdata, (m_own != 0) ? m_tx.wdata : 32'h0);
    chk("cpu_ack", 32'(cpu_ack), 32'(m_ack[1]));
    chk("host_ack", 32'(host_ack), 32'(m_ack[2]));
    chk("cpu_err", 32'(cpu_err), 32'(m_ack[1] & m_err));
    chk("host_err", 32'(host_err), 32'(m_ack[2] & m_err));
    chk("cpu_rdata", cpu_rdata, m_rd[1]);
    chk("host_rdata", host_rdata, m_rd[2]);
    if (mem_read) rd_cycles++;
    if (mem_write) begin
      wr_cycles++;
      wr_seen = mem_wrbits;
    end
    if (reset) m_step();
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_ack(input int port, input string nm, output int n);
    logic a;
    n = 0;
    a = 1'b0;
    while (!a && n < 50) begin
      step(1);
      n++;
      a = (port == 1) ? cpu_ack : host_ack;
    end
    chk({nm, "_ack_seen"}, 32'(a), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          r0;
    int          w0;
    bit          seen;
    logic [31:0] ord;

    cpu_req = 0; cpu_write = 0; cpu_addr = 0;
    cpu_wdata = 0; cpu_wrbits = 0;
    host_req = 0; host_write = 0; host_addr = 0;
    host_wdata = 0; host_wrbits = 0;

    step(3);
    reset = 1'b1;
    step(1);
    chk("rst_strobes",
        32'({mem_read, mem_write, cpu_ack, host_ack, mem_wrbits}), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // reset in the middle of a never-ready cpu load
    lat = 0;
    cpu_req = 1; cpu_addr = 32'h40;
    step(1);
    chk("rstmid_busy", 32'(mem_read), 32'h1);
    #1 reset = 1'b0;
    cpu_req = 0;
    #1 chk("rstmid_drop", 32'(mem_read), 32'h0);
    step(2);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step(1);
      if (cpu_ack) seen = 1'b1;
    end
    chk("rstmid_no_ack", 32'(seen), 32'h0);

    // cpu load, ready on third busy cycle
    lat = 3;
    rd_key = 32'h12345678 ^ 32'h100;
    r0 = rd_cycles;
    cpu_req = 1; cpu_write = 0; cpu_addr = 32'h100;
    wait_ack(1, "ld", n);
    cpu_req = 0;
    chk("ld_rdata", cpu_rdata, 32'h12345678);
    chk("ld_read_cycles", 32'(rd_cycles - r0), 32'd3);
    chk("ld_latency", 32'(n), 32'd4);

    // host store, ready on first busy cycle
    step(1);
    lat = 1;
    w0 = wr_cycles;
    host_req = 1; host_write = 1; host_addr = 32'h8;
    host_wdata = 32'hA5A5A5A5; host_wrbits = 4'b0011;
    wait_ack(2, "st", n);
    host_req = 0;
    chk("st_write_cycles", 32'(wr_cycles - w0), 32'd1);
    chk("st_wrbits", 32'(wr_seen), 32'h3);
    chk("st_latency", 32'(n), 32'd2);
    chk("st_rdata_hold", host_rdata, 32'h0);

    // contention: both loads held for four completions
    step(1);
    lat = 2;
    rd_key = 32'h55AA0000;
    host_write = 0; host_addr = 32'h20;
    cpu_write = 0; cpu_addr = 32'h10;
    cpu_req = 1; host_req = 1;
    ord = 32'h0;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      step(1);
      if (cpu_ack) begin ord = {ord[23:0], 8'h43}; n++; end
      if (host_ack) begin ord = {ord[23:0], 8'h48}; n++; end
    end
    cpu_req = 0; host_req = 0;
    chk("rr_order", ord, 32'h43484348);
    step(8);
    chk("rr_cpu_rdata", cpu_rdata, 32'h55AA0010);
    chk("rr_host_rdata", host_rdata, 32'h55AA0020);

    // captured address survives input changes
    lat = 4;
    rd_key = 32'h0;
    cpu_req = 1; cpu_addr = 32'h200;
    step(2);
    cpu_addr = 32'h999;
    step(1);
    chk("stable_addr", mem_addr, 32'h200);
    wait_ack(1, "stable", n);
    cpu_req = 0;
    chk("stable_rdata", cpu_rdata, 32'h200);

    // dropping req while busy still completes
    step(1);
    lat = 3;
    rd_key = 32'h0F0F0F0F;
    cpu_req = 1; cpu_addr = 32'h300;
    step(2);
    cpu_req = 0;
    wait_ack(1, "drop", n);
    chk("drop_rdata", cpu_rdata, 32'h0F0F0C0F);

    // mem_ready while idle must do nothing
    step(1);
    force_rdy = 1'b1;
    step(3);
    force_rdy = 1'b0;
    chk("idle_ready",
        32'({cpu_ack, host_ack, mem_read, mem_write}), 32'h0);
    step(2);

`ifdef MEM_ARB_TIMEOUT_EN
    lat = 0;
    r0 = rd_cycles;
    cpu_req = 1; cpu_addr = 32'h44;
    wait_ack(1, "to", n);
    cpu_req = 0;
    chk("to_err", 32'(cpu_err), 32'h1);
    chk("to_busy_cycles", 32'(rd_cycles - r0), 32'd4);
    chk("to_rdata_hold", cpu_rdata, 32'h0F0F0C0F);
    step(1);
    lat = 4;
    rd_key = 32'h11110000;
    cpu_req = 1; cpu_addr = 32'h44;
    wait_ack(1, "to_edge", n);
    cpu_req = 0;
    chk("to_edge_err", 32'(cpu_err), 32'h0);
    chk("to_edge_rdata", cpu_rdata, 32'h11110044);
`endif

    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
